// File: rtl/mem_bus_pkg.sv
`default_nettype none
// ============================================================================
// Package : mem_bus_pkg
// Brief   : Shared types and constants for the memory-mapped peripheral bus
//           (initiator and peripherals).
// Rev     : 1.0 - initial release
// ============================================================================
package mem_bus_pkg;

  localparam int DATA_W     = 16;
  localparam int BUS_ADDR_W = 16;

  // Initiator transaction states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    TURN   = 2'd2
  } bus_state_e;

  // One load/store request as seen on the bus
  typedef struct packed {
    logic                  we;
    logic [BUS_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     wdata;
  } bus_req_t;

endpackage
`default_nettype wire

// File: rtl/mem_bus_if.sv
`default_nettype none
// ============================================================================
// Interface : mem_bus_if
// Brief     : Core request/response handshake plus the bus control signals.
//             The tristate data pins stay a plain inout net on the initiator
//             so they resolve as an ordinary shared wire.
// Rev       : 1.0 - initial release
// ============================================================================
interface mem_bus_if #(
  parameter int ADDR_W = 16
);
  import mem_bus_pkg::*;

  // Core side
  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_we_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [DATA_W-1:0] req_wdata_i;
  logic              resp_valid_o;
  logic [DATA_W-1:0] resp_rdata_o;
  logic              resp_timeout_o;

  // Peripheral bus side
  logic [ADDR_W-1:0] bus_addr_o;
  logic              bus_re_o;
  logic              bus_we_o;
  logic              bus_needWait_i;

  // Initiator view
  modport master (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, bus_needWait_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_timeout_o,
    output bus_addr_o, bus_re_o, bus_we_o
  );

  // Core / peripheral view
  modport slave (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, bus_needWait_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_timeout_o,
    input  bus_addr_o, bus_re_o, bus_we_o
  );

endinterface
`default_nettype wire

// File: rtl/mem_bus_initiator.sv
`default_nettype none
// ============================================================================
// Module : mem_bus_initiator
// Brief  : Bus master for the shared peripheral bus. Accepts one load/store
//          from the core, runs a single bus access stretched by needWait,
//          aborts after MAX_WAIT stall cycles and returns a one-cycle
//          completion (or timeout) pulse with read data.
// Rev    : 1.0 - initial release
// ============================================================================
module mem_bus_initiator
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int MAX_WAIT   = 15,   // 1..255
  parameter int TURNAROUND = 1     // 0 or 1
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_bus_if.master         bus,
  inout  wire  [DATA_W-1:0] bus_data_io
);

  localparam logic [7:0] c_wait_limit = 8'(MAX_WAIT);
  localparam logic       c_use_turn   = (TURNAROUND != 0);

  bus_state_e        r_state;
  bus_state_e        w_state_nxt;
  logic              w_accept;
  logic              w_done;
  logic              w_abort;
  logic              w_end;

  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [7:0]        r_wait_cnt;
  logic              r_bus_re;
  logic              r_bus_we;
  logic              r_resp_valid;
  logic              r_resp_timeout;
  logic [DATA_W-1:0] r_rdata;

  // Next-state decode: accept in IDLE, finish or abort in ACCESS
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.req_valid_i) begin
          w_accept    = 1'b1;
          w_state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (!bus.bus_needWait_i) begin
          w_done = 1'b1;
        end else if (r_wait_cnt == c_wait_limit) begin
          w_abort = 1'b1;
        end
        // A read leaves a dead cycle so the peripheral releases the data pins
        if (w_done || w_abort) begin
          w_state_nxt = (!r_we && c_use_turn) ? TURN : IDLE;
        end
      end
      TURN: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_end = w_done | w_abort;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Request capture; held stable for the whole access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_we    <= bus.req_we_i;
      r_addr  <= bus.req_addr_i;
      r_wdata <= bus.req_wdata_i;
    end
  end

  // Bus strobes: raised on acceptance, dropped as the response is issued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bus_re <= 1'b0;
      r_bus_we <= 1'b0;
    end else if (w_accept) begin
      r_bus_re <= !bus.req_we_i;
      r_bus_we <= bus.req_we_i;
    end else if (w_end) begin
      r_bus_re <= 1'b0;
      r_bus_we <= 1'b0;
    end
  end

  // Stall counter: cleared per request, stops at the limit (abort takes over)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (w_accept) begin
      r_wait_cnt <= '0;
    end else if (r_state == ACCESS && bus.bus_needWait_i && !w_abort) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  // Completion pulse and read-data capture; rdata holds across aborts/writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_valid   <= 1'b0;
      r_resp_timeout <= 1'b0;
      r_rdata        <= '0;
    end else begin
      r_resp_valid   <= w_end;
      r_resp_timeout <= w_abort;
      if (w_done && !r_we) begin
        r_rdata <= bus_data_io;
      end
    end
  end

  assign bus.req_ready_o    = (r_state == IDLE);
  assign bus.resp_valid_o   = r_resp_valid;
  assign bus.resp_timeout_o = r_resp_timeout;
  assign bus.resp_rdata_o   = r_rdata;
  assign bus.bus_addr_o     = r_addr;
  assign bus.bus_re_o       = r_bus_re;
  assign bus.bus_we_o       = r_bus_we;

  // Data pins are driven only while the write strobe is up
  assign bus_data_io = r_bus_we ? r_wdata : {DATA_W{1'bz}};

endmodule
`default_nettype wire

// File: doc/mem_bus_initiator.md
Name: mem_bus_initiator

Overview:
- Bus-master end of the shared memory-mapped peripheral bus (addr / re / we / tristate 16-bit data / needWait).
- Accepts single load/store requests from the CPU core over a valid/ready handshake.
- Runs one bus transaction per request and stretches it while the addressed peripheral holds needWait high.
- Returns read data plus a completion/timeout pulse to the core; also drives the bus data pins during writes.

Parameters:
- ADDR_W, 16, width of the bus address.
- MAX_WAIT, 15, wait cycles tolerated before a transaction is aborted with timeout; legal range 1..255.
- TURNAROUND, 1, idle cycles forced after a read before the next request is accepted (0 or 1).

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid_i  input  1  core request present.
- req_ready_o  output  1  initiator can accept a request this cycle.
- req_we_i  input  1  1 = write, 0 = read.
- req_addr_i  input  ADDR_W  request address.
- req_wdata_i  input  16  write data.
- resp_valid_o  output  1  one-cycle completion pulse.
- resp_rdata_o  output  16  read data; valid with resp_valid_o on reads.
- resp_timeout_o  output  1  with resp_valid_o: transaction aborted after MAX_WAIT waits.
- bus_addr_o  output  ADDR_W  bus address.
- bus_re_o  output  1  bus read strobe.
- bus_we_o  output  1  bus write strobe.
- bus_data_io  inout  16  bus data; driven only while bus_we_o = 1, else high-Z.
- bus_needWait_i  input  1  peripheral extends the current access.

Behaviour:
- States: IDLE, ACCESS, TURN.
- Reset (async, rst_n = 0):
  - State = IDLE.
  - req_ready_o = 1 after release; resp_valid_o = 0; resp_timeout_o = 0; resp_rdata_o = 0.
  - bus_re_o = 0, bus_we_o = 0, bus_addr_o = 0, bus_data_io = Z, wait counter = 0.
  - Reset asserted mid-transaction drops the strobes and releases the data bus immediately, with no clock needed.
- IDLE:
  - req_ready_o = 1.
  - On an edge with req_valid_i & req_ready_o: latch addr, we and wdata into registers; clear wait counter; go to ACCESS.
- ACCESS:
  - Outputs are registered: bus_addr_o holds the latched address; bus_re_o = !we; bus_we_o = we; write data driven when we = 1.
  - Strobes are stable for the whole access. req_ready_o = 0.
  - Each edge with bus_needWait_i = 0 completes the access:
    - Read: capture bus_data_io into resp_rdata_o.
    - Next cycle: resp_valid_o = 1, resp_timeout_o = 0.
    - Next state: TURN if read and TURNAROUND = 1, else IDLE.
  - Each edge with bus_needWait_i = 1 increments the wait counter (8 bits).
    - If the counter already equals MAX_WAIT, abort instead: resp_valid_o = 1 and resp_timeout_o = 1 next cycle.
    - On abort, resp_rdata_o holds its previous value, strobes drop, and next state follows the same TURN/IDLE rule.
- TURN: strobes 0, bus high-Z, req_ready_o = 0; one cycle, then IDLE.
- Strobe release: bus_re_o and bus_we_o fall in the cycle resp_valid_o is high. The data bus is never driven in the cycle after a read strobe.
- Latency:
  - Zero-wait peripheral: request accepted at edge 0, strobe high in cycle 1, resp_valid_o high in cycle 2.
  - Each needWait cycle adds 1.
- Pulse widths: resp_valid_o and resp_timeout_o are exactly one cycle wide. resp_rdata_o holds until the next read completes.
- Request inputs are ignored while req_ready_o = 0.
- A write followed by any request: a new request can be accepted in the resp_valid_o cycle (state IDLE).

Decomposition:
- Package mem_bus_pkg:
  - State enum (IDLE / ACCESS / TURN).
  - Localparam DATA_W = 16.
  - Request struct {we, addr, wdata}.
  - Shared with bus peripherals.
- No sub-module. The tristate driver is a single continuous assign inside the block.

Test Plan:
- Zero-wait write: write addr 0x0000, data 0xBEEF to a zero-wait 16-bit register peripheral -> bus_we_o high exactly 1 cycle with bus_data_io = 0xBEEF; resp_valid_o at cycle 2, timeout 0; peripheral holds 0xBEEF.
- Zero-wait read back: read of the same peripheral -> bus_re_o 1 cycle; resp_rdata_o = 0xBEEF with resp_valid_o at cycle 2; req_ready_o low for the TURN cycle; bus_data_io never driven by the initiator.
- Wait states: peripheral holds needWait for 3 cycles on a read returning 0x1234 -> strobe high 4 cycles, resp_valid_o at cycle 5, rdata 0x1234, timeout 0.
- Timeout: needWait stuck high, MAX_WAIT = 15 -> abort after 16 strobe cycles; resp_valid_o = resp_timeout_o = 1 for one cycle; strobes 0, bus Z; next request accepted normally.
- Async reset mid-write: rst_n low during ACCESS with needWait high -> bus_we_o = 0 and bus_data_io = Z within the same cycle; after release req_ready_o = 1, resp_valid_o = 0.
- Back-to-back: write then write with req_valid_i held -> second request accepted in the first resp_valid_o cycle, 2-cycle throughput; req_valid_i pulsed during ACCESS is ignored.
